// File: rtl/ctr_cnt_gen_pkg.sv
// Shared helpers and state encoding for the ctr_cnt_gen / ctr_cnt_dec pair.
// Both blocks size and compare the count bus with the same functions.
package ctr_cnt_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Bits needed to hold the unsigned value val (at least 1).
  function automatic int bitWidthCal(input int val);
    int w;
    w = 1;
    while ((64'd1 << w) <= 64'(val)) w++;
    return w;
  endfunction

  function automatic int val2En(input int val);
    return (val != 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/ctr_cnt_gen.sv
// Run-length count generator feeding ctr_cnt_dec.in: sweeps FIRST..LAST once
// or repeatedly, with pause, abort and done/wrap signalling.
module ctr_cnt_gen
  import ctr_cnt_gen_pkg::*;
#(
  parameter string OUTTER_NAME  = "",
  parameter string MODULE_NAME  = "ctr_cnt_gen",
  parameter int    CNT_VAL      = 1024,
  parameter int    ZERO_VAL_EN  = 0,
  parameter int    AUTO_RESTART = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic pause,
  input  logic clear,
  output logic [bitWidthCal(CNT_VAL + val2En(ZERO_VAL_EN))-1:0] cnt,
  output logic busy,
  output logic hold,
  output logic first,
  output logic last,
  output logic wrap,
  output logic done
);

  localparam int ZE    = val2En(ZERO_VAL_EN);
  localparam int CNT_W = bitWidthCal(CNT_VAL + ZE);

  // IDLE_VAL sits outside FIRST..LAST so the decoder output is all-zero when idle.
  localparam logic [CNT_W-1:0] FIRST    = CNT_W'(1 - ZE);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CNT_VAL - ZE);
  localparam logic [CNT_W-1:0] IDLE_VAL = CNT_W'(ZE * CNT_VAL);

  if (CNT_VAL < 2) begin : g_bad_cnt_val
    $error("%s.%s: CNT_VAL=%0d must be at least 2", OUTTER_NAME, MODULE_NAME, CNT_VAL);
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             hold_q, hold_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = IDLE_VAL;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = IDLE_VAL;
          if (start) begin
            state_d = ST_RUN;
            cnt_d   = FIRST;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_HOLD;
          end else if (cnt_q == LAST) begin
            if (AUTO_RESTART != 0) begin
              cnt_d  = FIRST;
              wrap_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = IDLE_VAL;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          // Resume without stepping so the frozen value still gets its unpaused cycle.
          if (!pause) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = IDLE_VAL;
        end
      endcase
    end

    busy_d  = (state_d != ST_IDLE);
    hold_d  = (state_d == ST_HOLD);
    first_d = busy_d && (cnt_d == FIRST);
    last_d  = busy_d && (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= IDLE_VAL;
      busy_q  <= 1'b0;
      hold_q  <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      first_q <= first_d;
      last_q  <= last_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign cnt   = cnt_q;
  assign busy  = busy_q;
  assign hold  = hold_q;
  assign first = first_q;
  assign last  = last_q;
  assign wrap  = wrap_q;
  assign done  = done_q;

endmodule

// File: tb/tb_ctr_cnt_gen.sv
// Scoreboard bench for ctr_cnt_gen: three configurations share one stimulus
// stream and are checked against an index-based reference model.
module tb_ctr_cnt_gen;

  localparam int CV   [3] = '{8, 8, 4};
  localparam int ZEA  [3] = '{0, 1, 0};
  localparam int AUTO [3] = '{0, 0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [3:0] cnt0, cnt1;
  logic [2:0] cnt2;
  logic [2:0] busy, hold, first, last, wrap, done;

  ctr_cnt_gen #(.OUTTER_NAME("tb"), .MODULE_NAME("u0"), .CNT_VAL(8), .ZERO_VAL_EN(0), .AUTO_RESTART(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear), .cnt(cnt0),
    .busy(busy[0]), .hold(hold[0]), .first(first[0]), .last(last[0]), .wrap(wrap[0]), .done(done[0]));
  ctr_cnt_gen #(.OUTTER_NAME("tb"), .MODULE_NAME("u1"), .CNT_VAL(8), .ZERO_VAL_EN(1), .AUTO_RESTART(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear), .cnt(cnt1),
    .busy(busy[1]), .hold(hold[1]), .first(first[1]), .last(last[1]), .wrap(wrap[1]), .done(done[1]));
  ctr_cnt_gen #(.OUTTER_NAME("tb"), .MODULE_NAME("u2"), .CNT_VAL(4), .ZERO_VAL_EN(0), .AUTO_RESTART(1)) u2 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear), .cnt(cnt2),
    .busy(busy[2]), .hold(hold[2]), .first(first[2]), .last(last[2]), .wrap(wrap[2]), .done(done[2]));

  typedef logic [95:0] exp_t;
  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  // Reference model: sweep position as an index 0..CV-1 plus active/paused flags.
  int m_act [3] = '{0, 0, 0};
  int m_pau [3] = '{0, 0, 0};
  int m_idx [3] = '{0, 0, 0};

  function automatic logic [31:0] pack(input int c, input logic b, h, f, l, w, d);
    return {c[15:0], 10'd0, b, h, f, l, w, d};
  endfunction

  task automatic model_step(input logic r, s, p, c, output exp_t e);
    e = '0;
    for (int i = 0; i < 3; i++) begin
      logic w, d;
      int   v;
      w = 1'b0;
      d = 1'b0;
      if (r || c) begin
        m_act[i] = 0; m_pau[i] = 0; m_idx[i] = 0;
      end else if (m_act[i] == 0) begin
        if (s) begin m_act[i] = 1; m_idx[i] = 0; end
      end else if (m_pau[i] != 0) begin
        if (!p) m_pau[i] = 0;
      end else if (p) begin
        m_pau[i] = 1;
      end else if (m_idx[i] == CV[i] - 1) begin
        if (AUTO[i] != 0) begin m_idx[i] = 0; w = 1'b1; end
        else begin m_act[i] = 0; m_idx[i] = 0; d = 1'b1; end
      end else begin
        m_idx[i]++;
      end
      v = (m_act[i] != 0) ? (1 - ZEA[i]) + m_idx[i] : ZEA[i] * CV[i];
      e[i*32 +: 32] = pack(v, m_act[i] != 0, m_pau[i] != 0,
                           (m_act[i] != 0) && (m_idx[i] == 0),
                           (m_act[i] != 0) && (m_idx[i] == CV[i] - 1), w, d);
    end
  endtask

  task automatic drive(input logic r, s, p, c);
    exp_t e;
    @(negedge clk);
    rst = r; start = s; pause = p; clear = c;
    model_step(r, s, p, c, e);
    exp_q.push_back(e);
  endtask

  // Monitor: one expected bundle per clock edge once stimulus is flowing.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp_t        e;
        logic [31:0] act;
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          int c;
          c = (i == 0) ? int'(cnt0) : (i == 1) ? int'(cnt1) : int'(cnt2);
          act = pack(c, busy[i], hold[i], first[i], last[i], wrap[i], done[i]);
          n_chk++;
          if (act === e[i*32 +: 32]) n_pass++;
          else $display("FAIL out%0d cyc=%0d actual cnt=%0d bhflwd=%b required cnt=%0d bhflwd=%b",
                        i, cyc, act[31:16], act[5:0], e[i*32+16 +: 16], e[i*32 +: 6]);
        end
      end
    end
  end

  initial begin
    logic pl;
    // Reset and idle, then start+clear together must not start a sweep.
    drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    drive(0, 0, 0, 0); drive(0, 0, 0, 0);
    drive(0, 1, 0, 1); drive(0, 0, 0, 0);
    // Sweep with an ignored start at cnt=5 and a start in the done cycle.
    drive(0, 1, 0, 0);
    repeat (4) drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    // Pause three cycles at LAST of the 8-value sweep.
    repeat (7) drive(0, 0, 0, 0);
    repeat (3) drive(0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0);
    // Reset mid-run with pause held, then stay idle until a new start.
    drive(0, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 0);
    drive(1, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    repeat (6) drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    // Randomized traffic with bursty pause.
    pl = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 7) == 0) pl = ~pl;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 3, pl,
            $urandom_range(0, 49) == 0);
    end
    drive(0, 0, 0, 0);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
